alu_share_arb: RTL and testbench
================================

// Module: alu_share_arb
// PURPOSE
//  Shares one alu instance between NUM_REQ requesters (e.g. issue stage, address
//  generator, branch-compare unit). Each requester presents op/operands/tag on a
//  valid/ready port. A round-robin arbiter grants one request per cycle. The alu
//  result is captured in a single-entry output register with a valid/ready response port.
// PARAMETERS
//  NUM_REQ  2  requester count, legal 2..4
//  TAG_W    4  width of the opaque tag carried from request to response
//  SRC_W    $clog2(NUM_REQ) (local)  width of rsp_src
// PORTS
//  i_clk      in   1              clock; single clock domain
//  i_reset    in   1              synchronous, active-high reset
//  req_valid  in   NUM_REQ        per-requester request valid
//  req_ready  out  NUM_REQ        per-requester accept; at most one bit set
//  req_op     in   NUM_REQ*4      alu_op_e code; requester i uses bits [4i+3:4i]
//  req_a      in   NUM_REQ*32     operand_a, packed by index i
//  req_b      in   NUM_REQ*32     operand_b, packed by index i
//  req_tag    in   NUM_REQ*TAG_W  tag, packed by index i
//  rsp_valid  out  1              response register holds a result
//  rsp_ready  in   1              consumer accepts the response
//  rsp_data   out  32             alu result
//  rsp_tag    out  TAG_W          tag of the request that produced rsp_data
//  rsp_src    out  SRC_W          index of the requester that was granted
//  busy       out  1              rsp_valid | (|req_valid)
// BEHAVIOUR
//  Reset (synchronous, i_reset=1 at posedge):
//   - rsp_valid, rsp_data, rsp_tag and rsp_src reset to 0.
//   - RR pointer resets to 0, so requester 0 has highest priority first.
//   - While i_reset=1, req_ready is forced to 0.
//  Output FSM, two states:
//   - EMPTY (rsp_valid=0)
//   - FULL  (rsp_valid=1)
//   - can_accept = EMPTY | (FULL & rsp_ready)
//   - EMPTY -> FULL on accept.
//   - FULL -> EMPTY on rsp_ready with no accept.
//   - FULL -> FULL on rsp_ready & accept: drain and refill in the same cycle.
//   - FULL -> FULL on !rsp_ready: hold.
//  Arbitration:
//   - grant = first i with req_valid[i], searching from ptr, ptr+1, ... modulo NUM_REQ.
//   - req_ready = grant & {NUM_REQ{can_accept}}. req_ready depends combinationally on
//     req_valid and rsp_ready; requesters must not make valid depend on ready.
//   - On accept: ptr <= (granted index + 1) mod NUM_REQ. With no accept, ptr holds.
//  Datapath:
//   - Granted op/a/b feed the alu combinationally; alu_data is registered into rsp_data.
//   - Granted tag and index are registered into rsp_tag and rsp_src.
//   - Latency: request accepted at edge N gives rsp_valid=1 from edge N onward (visible cycle N+1).
//   - Throughput: 1 result/cycle while rsp_ready=1.
//  Arithmetic (entirely per alu):
//   - 32-bit wrap-around add/sub; SLT/SLTU return 0 or 1.
//   - Shifts use b[4:0]; LUI passes b.
//   - Undefined op codes give 0 and are still accepted and answered.
//  Stability:
//   - While rsp_valid & !rsp_ready, rsp_data/tag/src are held and all req_ready=0.
//   - A requester holding valid keeps its op/a/b/tag stable until its ready.
//  Fairness: with all requesters valid, each is granted once every NUM_REQ accepts.
//  Reset mid-operation: a pending response is discarded with no handshake and the pointer returns to 0.
// TESTING
//  1 Reset: i_reset=1 for 2 cycles, all req_valid=1 -> req_ready=0, rsp_valid=0;
//    first accept after release is requester 0.
//  2 Single request: req0 ADD a=5 b=7 tag=3, rsp_ready=1 -> next cycle rsp_valid=1,
//    rsp_data=12, rsp_tag=3, rsp_src=0.
//  3 Contention: req0 and req1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1;
//    req1 SUB a=3 b=5 -> rsp_data=0xFFFFFFFE.
//  4 Backpressure: rsp_ready=0 for 3 cycles while FULL -> rsp_* stable and req_ready=0;
//    rsp_ready=1 -> same-cycle accept of next request, SLT a=0xFFFFFFFF b=1 -> rsp_data=1.
//  5 Reset mid-flight: rsp_valid=1 and req1 pending, i_reset=1 one cycle -> rsp_valid=0;
//    next grant goes to req0 if valid.
//  6 Corners: SRA a=0x80000000 b=0x24 -> 0xF8000000; op=4'hF -> rsp_data=0 with valid response.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: one shared ALU behind a round-robin arbiter for NUM_REQ
// requesters, with a single-entry registered response (valid/ready).
// Op encoding (alu_op_e): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU,
// 7 SLL, 8 SRL, 9 SRA, 10 LUI; codes 11..15 are undefined and return 0.
module alu_share_arb #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*4-1:0]     req_op,
  input  logic [NUM_REQ*32-1:0]    req_a,
  input  logic [NUM_REQ*32-1:0]    req_b,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [$clog2(NUM_REQ)-1:0] rsp_src,
  output logic                     busy
);

  localparam int SRC_W = $clog2(NUM_REQ);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  // Pure ALU; undefined codes fall to zero so they still get a response.
  function automatic logic [31:0] alu_calc(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] res;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  res = a << b[4:0];
      OP_SRL:  res = a >> b[4:0];
      OP_SRA:  res = 32'($signed(a) >>> b[4:0]);
      OP_LUI:  res = b;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  logic             state;
  logic [SRC_W-1:0] ptr;
  logic             grant_found;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W:0]   cand_wide;
  logic             can_accept;
  logic             accept;
  logic [3:0]       sel_op;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      alu_data;
  logic [SRC_W-1:0] ptr_next;

  assign rsp_valid  = (state == ST_FULL);
  assign can_accept = (state == ST_EMPTY) | rsp_ready;
  assign accept     = grant_found & can_accept & ~i_reset;
  assign busy       = rsp_valid | (|req_valid);

  // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_wide   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_wide = {1'b0, ptr} + (SRC_W+1)'(k);
      if (cand_wide >= (SRC_W+1)'(NUM_REQ)) begin
        cand_wide = cand_wide - (SRC_W+1)'(NUM_REQ);
      end else begin
        cand_wide = cand_wide;
      end
      if (!grant_found && req_valid[cand_wide[SRC_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_wide[SRC_W-1:0];
      end else begin
        grant_found = grant_found;
      end
    end
  end

  // Steer the granted requester's fields into the ALU; ready goes only to the winner.
  always_comb begin
    sel_op    = 4'd0;
    sel_a     = 32'd0;
    sel_b     = 32'd0;
    sel_tag   = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_op       = req_op[4*i +: 4];
        sel_a        = req_a[32*i +: 32];
        sel_b        = req_b[32*i +: 32];
        sel_tag      = req_tag[TAG_W*i +: TAG_W];
        req_ready[i] = accept;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  assign alu_data = alu_calc(sel_op, sel_a, sel_b);

  // Pointer moves to the requester after the one just served.
  always_comb begin
    if (grant_idx == SRC_W'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + SRC_W'(1);
    end
  end

  // Output register FSM: fill on accept, drain on rsp_ready, hold otherwise.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_EMPTY;
      rsp_data <= 32'd0;
      rsp_tag  <= '0;
      rsp_src  <= '0;
      ptr      <= '0;
    end else if (accept) begin
      state    <= ST_FULL;
      rsp_data <= alu_data;
      rsp_tag  <= sel_tag;
      rsp_src  <= grant_idx;
      ptr      <= ptr_next;
    end else if (rsp_ready) begin
      state    <= ST_EMPTY;
    end else begin
      state    <= state;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb (NUM_REQ=2, TAG_W=4): a table of
// single-request ALU vectors plus hand-written arbitration/backpressure/reset sequences.
module tb_alu_share_arb;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic [0:0]  rsp_src;
  logic        busy;

  logic [3:0]  op_q  [2];
  logic [31:0] a_q   [2];
  logic [31:0] b_q   [2];
  logic [3:0]  tag_q [2];

  assign req_op  = {op_q[1], op_q[0]};
  assign req_a   = {a_q[1], a_q[0]};
  assign req_b   = {b_q[1], b_q[0]};
  assign req_tag = {tag_q[1], tag_q[0]};

  int checks   = 0;
  int failures = 0;

  alu_share_arb #(.NUM_REQ(2), .TAG_W(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_src(rsp_src), .busy(busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    int          src;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
    op_q[i] = op; a_q[i] = a; b_q[i] = b; tag_q[i] = tag;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  32'd5,          32'd7,          4'd3,  0, 32'd12};
    vecs[1]  = '{4'd1,  32'd3,          32'd5,          4'd2,  1, 32'hFFFF_FFFE};
    vecs[2]  = '{4'd2,  32'hF0F0_F0F0,  32'hFF00_FF00,  4'd4,  0, 32'hF000_F000};
    vecs[3]  = '{4'd3,  32'h0F00_00F0,  32'h00F0_000F,  4'd5,  1, 32'h0FF0_00FF};
    vecs[4]  = '{4'd4,  32'hFFFF_0000,  32'hFF00_FF00,  4'd6,  0, 32'h00FF_FF00};
    vecs[5]  = '{4'd5,  32'hFFFF_FFFF,  32'd1,          4'd7,  1, 32'd1};
    vecs[6]  = '{4'd6,  32'hFFFF_FFFF,  32'd1,          4'd8,  0, 32'd0};
    vecs[7]  = '{4'd7,  32'd1,          32'h21,         4'd9,  1, 32'd2};
    vecs[8]  = '{4'd8,  32'h8000_0000,  32'd4,          4'd10, 0, 32'h0800_0000};
    vecs[9]  = '{4'd9,  32'h8000_0000,  32'h24,         4'd11, 1, 32'hF800_0000};
    vecs[10] = '{4'd10, 32'd123,        32'hDEAD_0000,  4'd12, 0, 32'hDEAD_0000};
    vecs[11] = '{4'd0,  32'hFFFF_FFFF,  32'd2,          4'd13, 1, 32'd1};
    vecs[12] = '{4'hF,  32'h1234_5678,  32'h9ABC_DEF0,  4'd14, 0, 32'd0};
    vecs[13] = '{4'hB,  32'h0000_0001,  32'h0000_0001,  4'd15, 1, 32'd0};

    i_reset   = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    set_req(0, 4'd0, 32'd1, 32'd1, 4'd1);
    set_req(1, 4'd1, 32'd3, 32'd5, 4'd2);

    // Reset with all requesters valid: nothing accepted.
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_req_ready", {30'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    check("rst_rsp_data", rsp_data, 32'd0);
    i_reset = 1'b0;
    #1;
    check("first_grant_req0", {30'd0, req_ready}, 32'd1);

    // Contention: grants alternate 0,1,0,1.
    for (int c = 0; c < 4; c++) begin
      step();
      check("cont_valid", {31'd0, rsp_valid}, 32'd1);
      check("cont_src", {31'd0, rsp_src}, (c % 2 == 0) ? 32'd0 : 32'd1);
      check("cont_data", rsp_data, (c % 2 == 0) ? 32'd2 : 32'hFFFF_FFFE);
      check("cont_tag", {28'd0, rsp_tag}, (c % 2 == 0) ? 32'd1 : 32'd2);
    end
    req_valid = 2'b00;
    step();
    check("drain_valid", {31'd0, rsp_valid}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Table of single requests.
    for (int v = 0; v < 14; v++) begin
      set_req(vecs[v].src, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].tag);
      req_valid = (vecs[v].src == 0) ? 2'b01 : 2'b10;
      #1;
      check("vec_ready", {30'd0, req_ready}, {30'd0, req_valid});
      step();
      req_valid = 2'b00;
      #1;
      check("vec_valid", {31'd0, rsp_valid}, 32'd1);
      check("vec_data", rsp_data, vecs[v].exp);
      check("vec_tag", {28'd0, rsp_tag}, {28'd0, vecs[v].tag});
      check("vec_src", {31'd0, rsp_src}, vecs[v].src[31:0]);
      check("vec_busy", {31'd0, busy}, 32'd1);
      step();
      check("vec_drain", {31'd0, rsp_valid}, 32'd0);
    end

    // Backpressure: hold FULL for 3 cycles, then same-cycle drain and refill.
    set_req(0, 4'd0, 32'd10, 32'd20, 4'd5);
    req_valid = 2'b01;
    step();
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    set_req(1, 4'd5, 32'hFFFF_FFFF, 32'd1, 4'd6);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_req_ready", {30'd0, req_ready}, 32'd0);
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_data", rsp_data, 32'd30);
      check("bp_tag", {28'd0, rsp_tag}, 32'd5);
      check("bp_src", {31'd0, rsp_src}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_refill_ready", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = 2'b00;
    #1;
    check("bp_slt_data", rsp_data, 32'd1);
    check("bp_slt_tag", {28'd0, rsp_tag}, 32'd6);
    check("bp_slt_src", {31'd0, rsp_src}, 32'd1);
    step();

    // Reset mid-flight: pointer at 1 with a held response and req1 pending.
    rsp_ready = 1'b0;
    set_req(0, 4'd0, 32'd2, 32'd3, 4'd7);
    req_valid = 2'b01;
    step();
    req_valid = 2'b10;
    #1;
    check("mf_pending_valid", {31'd0, rsp_valid}, 32'd1);
    check("mf_pending_ready", {30'd0, req_ready}, 32'd0);
    i_reset   = 1'b1;
    req_valid = 2'b11;
    #1;
    check("mf_rst_ready", {30'd0, req_ready}, 32'd0);
    step();
    check("mf_rst_valid", {31'd0, rsp_valid}, 32'd0);
    i_reset   = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("mf_grant_req0", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    #1;
    check("mf_src", {31'd0, rsp_src}, 32'd0);
    check("mf_data", rsp_data, 32'd5);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
